// File: rtl/stream_extremum_finder_if.sv
// Sample-in / result-out handshake bundle for stream_extremum_finder.
// Optional signed_cmp wire exists only with STREAM_EXTREMUM_SIGNED_EN.
interface stream_extremum_finder_if #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8
);
  localparam int IDX_W =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic             mode;
`ifdef STREAM_EXTREMUM_SIGNED_EN
  logic             signed_cmp;
`endif
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic [IDX_W-1:0] out_index;
  logic [CNT_W-1:0] out_count;

  modport slave (
`ifdef STREAM_EXTREMUM_SIGNED_EN
    input  signed_cmp,
`endif
    input  mode,
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_value,
    output out_index,
    output out_count
  );

  modport master (
`ifdef STREAM_EXTREMUM_SIGNED_EN
    output signed_cmp,
`endif
    output mode,
    output in_valid,
    input  in_ready,
    output in_data,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_value,
    input  out_index,
    input  out_count
  );
endinterface

// File: rtl/stream_extremum_finder.sv
// Framed running max/min tracker with registered result handshake.
// Macro STREAM_EXTREMUM_SIGNED_EN adds two's-complement comparison.
module stream_extremum_finder #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8
) (
  input logic clk,
  input logic rst,
  stream_extremum_finder_if.slave bus
);
  localparam int IDX_W =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic ONE_SHOT = (FRAME_LEN == 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ACCUM = 2'b01;
  localparam logic [1:0] S_HOLD  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             sgn_q, sgn_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] oval_q, oval_d;
  logic [IDX_W-1:0] oidx_q, oidx_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  logic             sc_in;
  logic             in_acc;
  logic             out_acc;
  logic             close;
  logic             wins;

`ifdef STREAM_EXTREMUM_SIGNED_EN
  assign sc_in = bus.signed_cmp;
`else
  assign sc_in = 1'b0;
`endif

  assign in_acc  = bus.in_valid & in_ready_q;
  assign out_acc = out_valid_q & bus.out_ready;

  // strict win only, so ties keep the earlier index
  function automatic logic beats(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             mn,
    input logic             sg
  );
    logic gt;
    logic lt;
    if (sg) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return mn ? lt : gt;
  endfunction

  assign wins = beats(bus.in_data, best_q,
                      mode_q, sgn_q);

  // frame sequencing and running-extremum update
  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sgn_d   = sgn_q;
    close   = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (in_acc) begin
          best_d = bus.in_data;
          idx_d  = '0;
          cnt_d  = CNT_ONE;
          mode_d = bus.mode;
          sgn_d  = sc_in;
          close  = bus.in_last | ONE_SHOT;
          state_d = close ? S_HOLD : S_ACCUM;
        end
      end
      (state_q == S_ACCUM): begin
        if (in_acc) begin
          if (wins) begin
            best_d = bus.in_data;
            idx_d  = cnt_q[IDX_W-1:0];
          end
          cnt_d = cnt_q + CNT_ONE;
          close = bus.in_last |
                  (cnt_d == CNT_MAX);
          state_d = close ? S_HOLD : S_ACCUM;
        end
      end
      (state_q == S_HOLD): begin
        if (out_acc) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // result snapshot taken only as a frame closes
  always_comb begin
    oval_d = oval_q;
    oidx_d = oidx_q;
    ocnt_d = ocnt_q;
    if (close) begin
      oval_d = best_d;
      oidx_d = idx_d;
      ocnt_d = cnt_d;
    end
  end

  // handshake flags follow the next state
  always_comb begin
    in_ready_d  = (state_d != S_HOLD);
    out_valid_d = (state_d == S_HOLD);
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      best_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      oval_q      <= '0;
      oidx_q      <= '0;
      ocnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      sgn_q       <= sgn_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      oval_q      <= oval_d;
      oidx_q      <= oidx_d;
      ocnt_q      <= ocnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = oval_q;
  assign bus.out_index = oidx_q;
  assign bus.out_count = ocnt_q;

endmodule

// File: tb/tb_stream_extremum_finder.sv
// Directed bench for stream_extremum_finder.
// Signed cases build when STREAM_EXTREMUM_SIGNED_EN is defined.
module tb_stream_extremum_finder;
  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  stream_extremum_finder_if #(
    .WIDTH(4), .FRAME_LEN(8)
  ) bus ();

  stream_extremum_finder #(
    .WIDTH(4), .FRAME_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic push(input logic [3:0] d,
                      input logic last,
                      input logic md);
    chk("in_ready_pre", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.mode     = md;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic result(input string tag,
                        input logic [3:0] v,
                        input logic [2:0] i,
                        input logic [3:0] c);
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_value"}, 32'(bus.out_value), 32'(v));
    chk({tag, "_index"}, 32'(bus.out_index), 32'(i));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
    chk({tag, "_rdy0"}, 32'(bus.in_ready), 0);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
`ifdef STREAM_EXTREMUM_SIGNED_EN
    bus.signed_cmp = 1'b0;
`endif
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_value", 32'(bus.out_value), 0);
    chk("rst_index", 32'(bus.out_index), 0);
    chk("rst_count", 32'(bus.out_count), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus.in_ready), 1);

    push(4'd3, 1'b0, 1'b0);
    push(4'd9, 1'b0, 1'b0);
    push(4'd2, 1'b0, 1'b0);
    push(4'd9, 1'b1, 1'b0);
    result("max", 4'd9, 3'd1, 4'd4);
    drain();
    chk("hold_after_value", 32'(bus.out_value), 9);

    push(4'd5, 1'b0, 1'b1);
    push(4'd7, 1'b0, 1'b1);
    push(4'd1, 1'b0, 1'b1);
    push(4'd4, 1'b0, 1'b1);
    push(4'd1, 1'b0, 1'b1);
    push(4'd6, 1'b0, 1'b1);
    push(4'd15, 1'b0, 1'b1);
    push(4'd0, 1'b0, 1'b1);
    result("min_auto", 4'd0, 3'd7, 4'd8);
    drain();

    push(4'd4, 1'b0, 1'b0);
    push(4'd2, 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd15;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      result("bp", 4'd4, 3'd0, 4'd2);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    result("bp_end", 4'd4, 3'd0, 4'd2);
    drain();
    chk("bp_after_value", 32'(bus.out_value), 4);

    push(4'd12, 1'b0, 1'b0);
    push(4'd13, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(bus.out_valid), 0);
    chk("mrst_value", 32'(bus.out_value), 0);
    chk("mrst_count", 32'(bus.out_count), 0);
    chk("mrst_ready", 32'(bus.in_ready), 0);
    tick();
    push(4'd6, 1'b1, 1'b0);
    result("single", 4'd6, 3'd0, 4'd1);
    drain();

    push(4'd2, 1'b0, 1'b0);
    push(4'd10, 1'b0, 1'b1);
    push(4'd1, 1'b1, 1'b1);
    result("modechg", 4'd10, 3'd1, 4'd3);
    drain();

    bus.in_last = 1'b1;
    tick();
    bus.in_last = 1'b0;
    chk("idle_last_nv", 32'(bus.out_valid), 0);
    push(4'd7, 1'b0, 1'b0);
    push(4'd7, 1'b1, 1'b0);
    result("tie", 4'd7, 3'd0, 4'd2);
    drain();

`ifdef STREAM_EXTREMUM_SIGNED_EN
    bus.signed_cmp = 1'b1;
    push(4'b0111, 1'b0, 1'b0);
    bus.signed_cmp = 1'b0;
    push(4'b1000, 1'b1, 1'b0);
    result("signed", 4'b0111, 3'd0, 4'd2);
    drain();
    bus.signed_cmp = 1'b0;
    push(4'b0111, 1'b0, 1'b0);
    push(4'b1000, 1'b1, 1'b0);
    result("unsigned", 4'b1000, 3'd1, 4'd2);
    drain();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_extremum_finder.md
Name: stream_extremum_finder

Overview:
- Parametrised, sequential successor of the 4-bit combinational max selector in the ALU divider path.
- Consumes a stream of WIDTH-bit samples in frames and tracks the running maximum or minimum.
- Reports the extremum, its position in the frame, and the sample count through a valid/ready output handshake.
- Sits between operand sources and the ALU datapath; used for normalisation and operand ordering.

Parameters:
- WIDTH, 4, sample width in bits (>=1).
- FRAME_LEN, 8, maximum samples per frame (>=1); frame auto-closes when reached.
- IDX_W (localparam), max(1, clog2(FRAME_LEN)), index width.
- CNT_W (localparam), clog2(FRAME_LEN+1), count width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = track maximum, 1 = track minimum; sampled on the first sample of a frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  sample value.
- in_last  in  1  marks the final sample of the frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer accepts result.
- out_value  out  WIDTH  extremum value of the frame.
- out_index  out  IDX_W  zero-based position of the extremum within the frame.
- out_count  out  CNT_W  number of samples in the frame.

Behaviour:
- Reset: state=IDLE; in_ready=0 during the reset cycle, 1 on the first cycle after; out_valid=0; out_value, out_index, out_count=0; internal mode register=0.
- Reset mid-frame or while in HOLD discards all accumulated data and any pending result.
- Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- IDLE (in_ready=1, out_valid=0): on input accept:
  - load best=in_data, best_idx=0, count=1; latch mode.
  - if in_last or FRAME_LEN==1, go to HOLD; else go to ACCUM.
- ACCUM (in_ready=1): on input accept, the new sample is at position count.
  - It replaces best when strictly greater (mode=0) or strictly less (mode=1).
  - Ties keep the earliest index.
  - count increments.
  - If in_last, or the new count equals FRAME_LEN, go to HOLD.
- HOLD (in_ready=0, out_valid=1): out_value=best, out_index=best_idx, out_count=count, all stable while out_ready=0.
  - On output accept, go to IDLE next cycle.
  - No input is accepted in the handshake cycle, so there is one bubble per frame.
- Latency: out_valid asserts the cycle after the final sample is accepted.
- The mode input is ignored outside the first accepted sample; mid-frame changes have no effect.
- in_last is ignored when in_valid=0.
- Comparison is unsigned unless the optional feature is enabled.
- Outputs are registered; no combinational path from in_* to out_*.
- out_value/index/count hold their last values after the handshake; only out_valid deasserts.

Optional Feature:
- Macro: STREAM_EXTREMUM_SIGNED_EN.
- Defined: adds input port signed_cmp (1 bit), latched with mode on the first sample. When the latched value is 1, comparisons treat samples as two's complement.
- Undefined: port absent; all comparisons unsigned.

Test Plan:
- Max, unsigned (WIDTH=4, FRAME_LEN=8), mode=0: samples 3, 9, 2, 9 with in_last on the 4th -> out_valid one cycle later; value=9, index=1, count=4.
- Min, no in_last, mode=1: samples 5, 7, 1, 4, 1, 6, 15, 0 -> auto-close after the 8th; value=0, index=7, count=8; in_ready=0 in HOLD.
- Backpressure: complete frame 4, 2 (last), mode=0; hold out_ready=0 for 5 cycles -> out_valid stays 1, value=4, index=0, count=2 stable, in_ready=0, input pushes ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-frame: accept 12, 13, then assert rst for one cycle -> out_valid=0 and outputs zero. New frame 6 (last) -> value=6, index=0, count=1.
- Mode change mid-frame: start with mode=0 on sample 2, switch mode=1, send 10, 1 (last) -> value=10, index=1 (max retained).
- STREAM_EXTREMUM_SIGNED_EN, mode=0, samples 4'b0111, 4'b1000 (last):
  - signed_cmp=1 -> value=4'b0111, index=0.
  - signed_cmp=0 -> value=4'b1000, index=1.
